prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 6, instruction memory address width (64 words).
REQ-002 Parameter WORD_W, default 16, instruction word width; SHALL be 16 (two bytes per word).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a load session.
REQ-006 byte_valid  input  1  host byte strobe.
REQ-007 byte_data  input  8  host byte.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 inst_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 inst_addr  output  ADDR_W  instruction memory write address.
REQ-011 inst_wdata  output  WORD_W  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor in reset while high.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  load completed successfully, level until next start.
REQ-015 err  output  1  load failed, level until next start.

Function
REQ-016 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both high; byte_data is ignored otherwise.
REQ-017 States SHALL be IDLE, COUNT, HI, LO, CHK, FIN, ERR; byte_ready high only in COUNT, HI, LO, CHK.
REQ-018 IDLE/FIN/ERR: start -> COUNT; word counter and address cleared; done, err cleared; start in COUNT/HI/LO/CHK is ignored.
REQ-019 COUNT: accepted byte N; N=0 or N>2^ADDR_W -> ERR; else store N, -> HI.
REQ-020 HI: accepted byte latched as bits [15:8] of the word, -> LO.
REQ-021 LO: accepted byte forms bits [7:0]; inst_we SHALL pulse high exactly one cycle, in the cycle after acceptance, with inst_addr = word index (0,1,2,...) and inst_wdata = {hi,lo}.
REQ-022 After the LO write of word N-1 the FSM SHALL go to CHK (macro defined) or FIN (macro undefined); otherwise back to HI with address incremented.
REQ-023 inst_addr SHALL never wrap: N is bounded by REQ-019, so the last address is N-1.
REQ-024 inst_we SHALL be low in all cycles other than those of REQ-021; inst_addr/inst_wdata hold their last values between writes.
REQ-025 busy SHALL be high in COUNT, HI, LO, CHK and until the final inst_we pulse has completed.
REQ-026 cpu_hold SHALL be high from reset and throughout any session and in ERR; low only in FIN, and in IDLE after reset release only if never loaded is false -- i.e. cpu_hold low only after a successful load.
REQ-027 FIN: done=1, cpu_hold=0. ERR: err=1, cpu_hold=1.
REQ-028 Back-to-back bytes (byte_valid high every cycle) SHALL be accepted with no stalls; byte_ready SHALL not depend combinationally on byte_valid.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, byte_ready=0, inst_we=0, inst_addr=0, inst_wdata=0, busy=0, done=0, err=0, cpu_hold=1, checksum accumulator=0.
REQ-030 rst asserted mid-session SHALL abort with no further inst_we pulse; words already written are not rolled back.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: a running XOR of every accepted HI and LO byte is kept; in CHK one further byte is accepted; equal -> FIN, unequal -> ERR.
REQ-032 LOADER_CHECKSUM_EN undefined: CHK state and accumulator are absent; the last LO write leads directly to FIN; err arises only from REQ-019.

Verification
REQ-033 start, bytes 02,12,34,AB,CD (+ checksum 40 if enabled) -> inst_we at addr 0 data 1234, addr 1 data ABCD, then done=1, cpu_hold=0, err=0.
REQ-034 start, count byte 00 -> err=1, cpu_hold=1, no inst_we; count byte 41 -> same.
REQ-035 LOADER_CHECKSUM_EN: bytes 01,12,34, checksum 00 -> word written at addr 0, then err=1, done=0, cpu_hold=1.
REQ-036 rst low after 01,12 accepted -> all outputs at reset values immediately, no inst_we; next start with 01,55,AA(,FF) -> addr 0 data 55AA, done=1.
REQ-037 count 40 with 128 data bytes driven back-to-back -> 64 writes, addresses 00..3F in order, byte_ready never drops before CHK/FIN; start pulses during the session have no effect.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream boot loader: count byte then hi/lo byte pairs written as 16-bit words, CPU held until success.
// One write per word, the cycle after the lo byte; byte_ready depends only on state, so no stalls mid-session. Define LOADER_CHECKSUM_EN for the XOR trailer byte.
module prog_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [WORD_W-1:0] inst_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHK, FIN, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, FIN, ERR} state_t;
`endif

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        n_words;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        hi_q;
  logic              accept;
  logic              count_bad;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == COUNT) || (state_q == HI) || (state_q == LO) || (state_q == CHK);
`else
  assign byte_ready = (state_q == COUNT) || (state_q == HI) || (state_q == LO);
`endif

  assign accept    = byte_valid && byte_ready;
  assign count_bad = (byte_data == 8'd0) || (32'(byte_data) > MAX_WORDS);
  assign last_word = (32'(word_idx) + 32'd1) == 32'(n_words);
  // The final write pulse lands in the first FIN/CHK cycle, so it extends busy.
  assign busy      = byte_ready || inst_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN, ERR: if (start) state_d = COUNT;
      COUNT:          if (accept) state_d = count_bad ? ERR : HI;
      HI:             if (accept) state_d = LO;
`ifdef LOADER_CHECKSUM_EN
      LO:             if (accept) state_d = last_word ? CHK : HI;
      CHK:            if (accept) state_d = (byte_data == csum_q) ? FIN : ERR;
`else
      LO:             if (accept) state_d = last_word ? FIN : HI;
`endif
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words    <= '0;
      word_idx   <= '0;
      hi_q       <= '0;
      inst_we    <= 1'b0;
      inst_addr  <= '0;
      inst_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      inst_we <= 1'b0;
      case (state_q)
        IDLE, FIN, ERR: begin
          if (start) begin
            word_idx <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        COUNT: begin
          if (accept) begin
            n_words <= byte_data;
            if (count_bad) err <= 1'b1;
          end
        end
        HI: begin
          if (accept) begin
            hi_q <= byte_data;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ byte_data;
`endif
          end
        end
        LO: begin
          if (accept) begin
            inst_we    <= 1'b1;
            inst_addr  <= word_idx;
            inst_wdata <= {hi_q, byte_data};
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ byte_data;
            if (!last_word) word_idx <= word_idx + ADDR_W'(1);
`else
            if (!last_word) begin
              word_idx <= word_idx + ADDR_W'(1);
            end else begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (byte_data == csum_q) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err      <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
